// File: rtl/signed_sequential_divider_if.sv
// Start/done handshake and operand/result bundle for the signed sequential divider.
// master drives the request side; slave is the divider itself.
interface signed_sequential_divider_if #(
    parameter int n = 8
);
    logic         start;
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic         overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, divByZero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, divByZero, overflow
    );
endinterface

// File: rtl/signed_sequential_divider.sv
// Signed restoring divider, one quotient bit per clock, truncating toward zero.
// Latency n+1 clocks (1 for divide-by-zero); start is ignored while busy.
module signed_sequential_divider #(
    parameter int n = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    signed_sequential_divider_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

    localparam int           CW       = $clog2(n + 1);
    localparam logic [n-1:0] MOST_NEG = {1'b1, {(n-1){1'b0}}};

    state_t       state, state_nxt;
    logic [n-1:0] r_q, q_q, mag_d, dvd;
    logic [CW-1:0] cnt;
    logic         sign_q, sign_r, dz, ov;
    logic [n-1:0] mag_a_in, mag_d_in;
    logic [n:0]   shifted, trial;

    logic [n-1:0] quotient, remainder;
    logic         busy, done, div_by_zero, overflow;

    assign mag_a_in = bus.dividend[n-1] ? -bus.dividend : bus.dividend;
    assign mag_d_in = bus.divisor[n-1]  ? -bus.divisor  : bus.divisor;

    // Partial remainder stays below |divisor| <= 2^(n-1), so n stored bits
    // suffice; only the shifted trial value needs the extra bit.
    assign shifted = {r_q, q_q[n-1]};
    assign trial   = shifted - {1'b0, mag_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? FIXUP : DIVIDE;
            DIVIDE:  if (cnt == CW'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            mag_d       <= '0;
            dvd         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            ov          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q      <= bus.dividend[n-1] ^ bus.divisor[n-1];
                        sign_r      <= bus.dividend[n-1];
                        mag_d       <= mag_d_in;
                        dvd         <= bus.dividend;
                        dz          <= (bus.divisor == '0);
                        ov          <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                        r_q         <= '0;
                        q_q         <= mag_a_in;
                        cnt         <= CW'(n);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DIVIDE: begin
                    r_q <= trial[n] ? shifted[n-1:0] : trial[n-1:0];
                    q_q <= {q_q[n-2:0], ~trial[n]};
                    cnt <= cnt - CW'(1);
                end
                FIXUP: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= dvd;
                        div_by_zero <= 1'b1;
                    end else if (ov) begin
                        quotient  <= MOST_NEG;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -q_q : q_q;
                        remainder <= sign_r ? -r_q : r_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.divByZero = div_by_zero;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_signed_sequential_divider.sv
// Bench for signed_sequential_divider: vector table plus hand sequences, results
// matched against a queue of expectations pushed when each start is driven.
module tb_signed_sequential_divider;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_sequential_divider_if #(.n(8)) dif();
    signed_sequential_divider #(.n(8)) dut (.clk(clk), .rst(rst), .bus(dif));

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   e_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops one expectation per done pulse, checks pulse width and hold.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    check("done_one_cycle", {31'b0, dif.done}, 32'd0);
                    check("quotient_held", {24'b0, dif.quotient}, {24'b0, last_exp.q});
                end
                if (dif.done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
                    end else begin
                        last_exp = sb.pop_front();
                        check("quotient",  {24'b0, dif.quotient},  {24'b0, last_exp.q});
                        check("remainder", {24'b0, dif.remainder}, {24'b0, last_exp.r});
                        check("divByZero", {31'b0, dif.divByZero}, {31'b0, last_exp.dz});
                        check("overflow",  {31'b0, dif.overflow},  {31'b0, last_exp.ov});
                    end
                end
                prev_done = dif.done;
            end
        end
    end

    // Called just after a falling edge; returns one falling edge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                         input logic [7:0] r, input logic dz, input logic ov);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov;
        dif.dividend = a;
        dif.divisor  = b;
        dif.start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e_cyc = cyc;
        @(negedge clk);
        dif.start = 1'b0;
        check("busy_after_start", {31'b0, dif.busy}, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (dif.done) begin
                lat = cyc - e_cyc;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done within 40 cycles expected done (t=%0t)", $time);
        end else begin
            check("busy_at_done", {31'b0, dif.busy}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[14];
        int   lat;

        vt[0]  = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9};
        vt[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9};
        vt[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9};
        vt[3]  = '{8'hF9, 8'h64, 8'h00, 8'hF9, 1'b0, 1'b0, 9};
        vt[4]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9};
        vt[5]  = '{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 9};
        vt[6]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1};
        vt[7]  = '{8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0, 9};
        vt[8]  = '{8'h80, 8'h07, 8'hEE, 8'hFE, 1'b0, 1'b0, 9};
        vt[9]  = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 9};
        vt[10] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 9};
        vt[11] = '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0, 9};
        vt[12] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0, 1};
        vt[13] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9};

        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient",  {24'b0, dif.quotient},  32'd0);
        check("rst_remainder", {24'b0, dif.remainder}, 32'd0);
        check("rst_busy",      {31'b0, dif.busy},      32'd0);
        check("rst_done",      {31'b0, dif.done},      32'd0);
        check("rst_divByZero", {31'b0, dif.divByZero}, 32'd0);
        check("rst_overflow",  {31'b0, dif.overflow},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].r, vt[i].dz, vt[i].ov);
            wait_done(lat);
            check($sformatf("latency_vec%0d", i), lat, vt[i].lat);
        end

        // A start pulse mid-operation must not disturb the result in flight.
        issue(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("held_during_op", {24'b0, dif.quotient}, 32'h80);
        dif.start    = 1'b1;
        dif.dividend = 8'd50;
        dif.divisor  = 8'd5;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(lat);
        check("latency_ignored_start", lat, 9);
        issue(8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 1'b0);
        wait_done(lat);
        check("latency_back_to_back", lat, 9);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        issue(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_quotient",  {24'b0, dif.quotient},  32'd0);
        check("abort_remainder", {24'b0, dif.remainder}, 32'd0);
        check("abort_busy",      {31'b0, dif.busy},      32'd0);
        check("abort_done",      {31'b0, dif.done},      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_resume", {31'b0, dif.busy}, 32'd0);
        issue(8'd9, 8'd2, 8'h04, 8'h01, 1'b0, 1'b0);
        wait_done(lat);
        check("latency_after_reset", lat, 9);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/signed_sequential_divider.md
Name: signed_sequential_divider

Overview:
Signed restoring sequential divider. It is the inverse-direction companion to the signed sequential multiplier. It retires one quotient bit per clock: the remainder:quotient pair shifts left and the divisor is trial-subtracted, the mirror of the multiplier's add-and-shift-right product register. It sits beside the multiplier in the arithmetic datapath, behind the same start/done handshake style. Results use truncation toward zero, i.e. C/Verilog signed semantics.

Parameters:
n, 8, operand width in bits; dividend, divisor, quotient and remainder are all n bits, two's complement.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  n  signed dividend; captured on the accepted start edge
divisor  input  n  signed divisor; captured on the accepted start edge
quotient  output  n  signed quotient; held until the next accepted start
remainder  output  n  signed remainder; sign follows the dividend; held
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when quotient/remainder become valid
divByZero  output  1  set with done when divisor==0; held until next start
overflow  output  1  set with done for most-negative / -1; held until next start

Behaviour:
- Reset (async, any state): state=IDLE; quotient, remainder, busy, done, divByZero, overflow = 0; internal counter and registers = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, DIVIDE, FIXUP.
- IDLE, on start=1 at edge E:
  - Capture signQ = dividend[n-1]^divisor[n-1] and signR = dividend[n-1].
  - Capture n-bit unsigned magnitudes |dividend| and |divisor|. |most-negative| = 2^(n-1) fits in n bits unsigned.
  - Clear divByZero and overflow.
  - If divisor==0, go to FIXUP. Otherwise load partial remainder (n+1 bits) = 0, quotient shift register = |dividend|, counter = n, and go to DIVIDE.
  - busy rises at E.
- DIVIDE, one iteration per edge:
  - {R,Q} shifts left 1.
  - T = R - |divisor| at n+1 bits.
  - If T >= 0, R = T and Q[0] = 1; else R is restored (unchanged) and Q[0] = 0.
  - Counter decrements. After the n-th iteration, go to FIXUP.
- FIXUP, a single edge that writes the outputs, pulses done=1 for exactly one cycle, drops busy and returns to IDLE:
  - Normal case: quotient = signQ ? -Q : Q; remainder = signR ? -R[n-1:0] : R[n-1:0].
  - Divide by zero: quotient = all ones, remainder = dividend, divByZero = 1.
  - Overflow (dividend = -2^(n-1), divisor = -1): quotient = -2^(n-1) (the natural wrap), remainder = 0, overflow = 1.
- Latency, start edge E to done:
  - Normal: done high in the cycle after edge E+n+1, i.e. n+1 clocks.
  - Divide by zero: 1 clock.
  - Back-to-back: the next start is accepted on the edge after done, so throughput is n+2 cycles per op.
- start while busy: ignored. Operands are not re-sampled and the in-flight result is unaffected.
- start held high continuously: a new operation begins each time IDLE is re-entered.
- Outputs stay stable between done pulses. They change only at FIXUP or reset.
- All width arithmetic is modulo 2^n except the n+1-bit trial subtraction. No saturation.

Test Plan:
- n=8: 100/7 -> done exactly 9 clocks after start edge; quotient=14 (0x0E), remainder=2; busy high for 9 cycles; divByZero=overflow=0.
- -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2). 100/-7 -> quotient=0xF2, remainder=0x02. -7/100 -> quotient=0x00, remainder=0xF9.
- -128/-1 -> quotient=0x80, remainder=0x00, overflow=1, done at 9 clocks. Then 127/1 -> quotient=0x7F, overflow cleared.
- 5/0 -> done 1 clock after start; quotient=0xFF, remainder=0x05, divByZero=1. Next op 6/3 -> quotient=2, divByZero=0.
- Start 100/7, pulse start with 50/5 at cycle 3 -> second start ignored, result is 14 r 2. Then 50/5 issued on the cycle after done -> quotient=10, remainder=0.
- Start 100/7, assert rst at cycle 4 -> all outputs 0 immediately, no done pulse. Release rst, run 9/2 -> quotient=4, remainder=1.
